rom_read_arbiter: RTL and testbench
===================================

# rom_read_arbiter

Two-requester burst-read controller for the 16384 x 24 synchronous-address ROM. It shares the ROM between requesters 0 and 1 using round-robin arbitration at burst boundaries. It sequences the ROM's address and output-enable pins so that one word is delivered per cycle. Each requester receives its words on a shared data bus, qualified by a per-requester valid strobe and an end-of-burst pulse.

## Interface
- AW, 14: ROM address width; address space 2^AW words.
- DW, 24: ROM data width.
- LW, 8: burst-length field width; burst = LEN+1 words (1..2^LW).

Ports:
- CK  input  1: clock; all state updates on rising edge.
- RST_N  input  1: asynchronous, active-low reset.
- REQ0 / REQ1  input  1: burst request; held high with ADDRx/LENx stable until GNTx.
- ADDR0 / ADDR1  input  AW: start word address.
- LEN0 / LEN1  input  LW: words minus one.
- GNT0 / GNT1  output  1: one-cycle acceptance pulse.
- RDATA  output  DW: read word, shared by both requesters.
- RVALID0 / RVALID1  output  1: RDATA belongs to requester x this cycle.
- DONE0 / DONE1  output  1: last word of x's burst; coincident with its final RVALIDx.
- ROM_A  output  AW: to ROM address pin; the ROM latches it on the CK rising edge.
- ROM_OE  output  1: to ROM output enable. ROM_Q is valid in the cycle after the edge that latched ROM_A, while ROM_OE=1.
- ROM_Q  input  DW: ROM data.

## Operation
- States: IDLE, READ, DRAIN.
- IDLE:
  - ROM_OE=0.
  - At an edge with any REQ high: select winner, latch its ADDR into ROM_A and its LEN into the remaining-issue counter, pulse GNTwinner for one cycle, record owner, go to READ.
- Arbitration:
  - Only one REQ high: that requester wins.
  - Both high: the requester not granted last wins.
  - The last-grant pointer resets so requester 0 wins the first tie.
  - The pointer updates only on grant.
- READ:
  - ROM_OE=1.
  - Each edge: if counter>0, ROM_A <= (ROM_A+1) mod 2^AW and counter decrements; else go to DRAIN.
- DRAIN:
  - ROM_OE=1.
  - At the next edge, capture the final word, go to IDLE.
- Capture rule: at every edge in READ or DRAIN, if the ROM latched a burst address at the preceding edge, then RDATA <= ROM_Q and RVALIDowner <= 1. Otherwise both RVALIDs go to 0.
- DONEowner=1 together with the RVALID of the (LEN+1)th word.
- RDATA holds its last value when no RVALID is asserted.
- Address wraps modulo 2^AW; no error is raised.
- A REQ still high after DONE is treated as a new request and re-arbitrated in IDLE.
- REQ changes during a burst are ignored.

## Timing
- Reset (async, immediate) values:
  - state=IDLE, GNT0/1=0, RVALID0/1=0, DONE0/1=0.
  - RDATA=0, ROM_A=0, ROM_OE=0.
  - Last-grant pointer = 1, so requester 0 has priority.
- Edge E0 = grant edge:
  - GNT high in cycle E0..E1.
  - ROM_A = start address after E0; ROM latches it at E1.
  - First RVALID is high after E2, giving a 2-cycle latency from the grant edge.
- N = LEN+1 words:
  - RVALID is high for cycles E2..E(N+1), contiguous, one word per cycle.
  - DONE is high after E(N+1).
  - ROM_OE is high from E0 until E(N+1).
  - State returns to IDLE at E(N+1).
- Earliest next GNT is at E(N+2), so there is one idle bubble between bursts.
- Reset asserted mid-burst: the burst is abandoned with no DONE, and all outputs take their reset values immediately.
- After RST_N deasserts, arbitration resumes at the first edge.

## Test plan
- Single word: REQ0, ADDR0=5, LEN0=0 -> GNT0 at E0; RVALID0=DONE0=1 after E2 with RDATA=mem[5]; ROM_OE low after E2.
- Burst: REQ1, ADDR1=100, LEN1=3 -> RDATA = mem[100..103] on consecutive cycles after E2..E5; DONE1 only with mem[103]; RVALID0 stays 0.
- Wrap: ADDR0=16382, LEN0=3 -> ROM_A sequence 16382, 16383, 0, 1; four valid words, DONE0 on mem[1].
- Round-robin: REQ0 and REQ1 both held high after reset, LEN=1 each -> grants in order 0, 1, 0, 1. One idle cycle between bursts; no overlap of RVALID0 and RVALID1.
- Reset mid-burst: LEN0=7, pull RST_N low after 3 valid words -> all outputs 0 asynchronously, no DONE0. After release, a pending REQ1 is granted at the first edge.
- Max length: LEN0=255 -> exactly 256 contiguous RVALID0 cycles, DONE0 on the 256th; ROM_A ends at ADDR0+255.

Source files
------------

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter
// Two-requester burst-read controller for a synchronous-address ROM.
// Requests are accepted only at burst boundaries. Requester 0 and requester 1
// share the ROM round-robin, and one word is delivered per cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req0/req1           burst request, held with addr/len stable until gnt
//   addr0/addr1         start word address
//   len0/len1           burst length minus one
//   gnt0/gnt1           one-cycle acceptance pulse
//   rdata               shared read data bus
//   rvalid0/rvalid1     rdata belongs to requester x this cycle
//   done0/done1         last word of requester x's burst (with its rvalid)
//   rom_a, rom_oe       ROM address and output-enable pins
//   rom_q               ROM data, valid the cycle after rom_a was latched
module rom_read_arbiter #(
  parameter int unsigned AW = 14,
  parameter int unsigned DW = 24,
  parameter int unsigned LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [LW-1:0] len0,
  input  logic [LW-1:0] len1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          done0,
  output logic          done1,
  output logic [AW-1:0] rom_a,
  output logic          rom_oe,
  input  logic [DW-1:0] rom_q
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t        state;
  logic [LW-1:0] cnt;        // addresses still to issue after the current one
  logic          owner;      // requester that owns the current burst
  logic          last_gnt;   // requester granted most recently
  logic          issued;     // ROM latched a burst address at the previous edge

  logic          win_c;
  logic [AW-1:0] win_addr_c;
  logic [LW-1:0] win_len_c;

  // Winner selection: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    win_c = 1'b0;
    if (req0 && req1) begin
      win_c = ~last_gnt;
    end else if (req1) begin
      win_c = 1'b1;
    end
    win_addr_c = win_c ? addr1 : addr0;
    win_len_c  = win_c ? len1  : len0;
  end

  // Burst sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      issued   <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rdata    <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      rom_a    <= '0;
      rom_oe   <= 1'b0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      issued  <= (state == READ);

      // The word addressed one edge ago is on rom_q now; the capture made in
      // DRAIN is always the final word of the burst.
      if ((state == READ || state == DRAIN) && issued) begin
        rdata   <= rom_q;
        rvalid0 <= ~owner;
        rvalid1 <= owner;
        done0   <= (state == DRAIN) && !owner;
        done1   <= (state == DRAIN) && owner;
      end

      case (state)
        IDLE: begin
          if (req0 || req1) begin
            rom_a    <= win_addr_c;
            cnt      <= win_len_c;
            gnt0     <= ~win_c;
            gnt1     <= win_c;
            owner    <= win_c;
            last_gnt <= win_c;
            rom_oe   <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          if (cnt != '0) begin
            rom_a <= rom_a + AW'(1);
            cnt   <= cnt - LW'(1);
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          rom_oe <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench for rom_read_arbiter: stimulus pushes the expected words
// and grant order, and a monitor pops and compares as the DUT presents them.
module tb_rom_read_arbiter;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 24;
  localparam int unsigned LW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [AW-1:0] addr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [LW-1:0] len0 = '0, len1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, done0, done1, rom_oe;
  logic [DW-1:0] rdata, rom_q, rom_q_r;
  logic [AW-1:0] rom_a;

  exp_t sq0[$];
  exp_t sq1[$];
  int   gq[$];

  int checks = 0;
  int errors = 0;
  int vcount0 = 0;
  bit end_req = 1'b0;
  bit mon_done = 1'b0;

  rom_read_arbiter #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .len0(len0), .len1(len1), .gnt0(gnt0), .gnt1(gnt1),
    .rdata(rdata), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .done0(done0), .done1(done1), .rom_a(rom_a), .rom_oe(rom_oe),
    .rom_q(rom_q)
  );

  always #5 clk = ~clk;

  // Distinct content per address: upper 14 bits are a bijection of the address.
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    logic [9:0] lo;
    lo = 10'(a[9:0] * 10'd7);
    return {a ^ 14'h2A5C, lo};
  endfunction

  // ROM model: address latched at the rising edge, data driven while rom_oe.
  always @(posedge clk) rom_q_r <= rom_word(rom_a);
  assign rom_q = rom_oe ? rom_q_r : '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: the only process that compares and counts.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        chk("reset_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("reset_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        chk("reset_done", {30'd0, done1, done0}, 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        chk("reset_rom_a", 32'(rom_a), 32'd0);
        chk("reset_rom_oe", 32'(rom_oe), 32'd0);
        sq0.delete();
        sq1.delete();
        gq.delete();
      end else begin
        if (gnt0 || gnt1) begin
          chk("gnt_onehot", {30'd0, gnt1, gnt0} & 32'd3, gnt1 ? 32'd2 : 32'd1);
          if (gq.size() == 0) begin
            chk("gnt_unexpected", {31'd0, gnt1}, 32'hFFFF_FFFF);
          end else begin
            chk("gnt_owner", {31'd0, gnt1}, 32'(gq.pop_front()));
          end
          chk("gnt_bubble", {30'd0, rvalid1, rvalid0}, 32'd0);
          chk("gnt_rom_oe", 32'(rom_oe), 32'd1);
        end
        if (rvalid0 || rvalid1) chk("rvalid_overlap", {31'd0, rvalid0 & rvalid1}, 32'd0);
        if (done0) chk("done0_with_rvalid0", 32'(rvalid0), 32'd1);
        if (done1) chk("done1_with_rvalid1", 32'(rvalid1), 32'd1);
        if (rvalid0) begin
          vcount0++;
          if (sq0.size() == 0) begin
            chk("rvalid0_unexpected", 32'(rdata), 32'hFFFF_FFFF);
          end else begin
            e = sq0.pop_front();
            chk("rdata0", 32'(rdata), 32'(e.data));
            chk("done0", 32'(done0), 32'(e.last));
            if (e.last) begin
              chk("rom_a_end0", 32'(rom_a), 32'(e.addr));
              chk("rom_oe_off0", 32'(rom_oe), 32'd0);
            end
          end
        end
        if (rvalid1) begin
          if (sq1.size() == 0) begin
            chk("rvalid1_unexpected", 32'(rdata), 32'hFFFF_FFFF);
          end else begin
            e = sq1.pop_front();
            chk("rdata1", 32'(rdata), 32'(e.data));
            chk("done1", 32'(done1), 32'(e.last));
            if (e.last) begin
              chk("rom_a_end1", 32'(rom_a), 32'(e.addr));
              chk("rom_oe_off1", 32'(rom_oe), 32'd0);
            end
          end
        end
        if (end_req && !mon_done) begin
          chk("leftover_words", 32'(sq0.size() + sq1.size()), 32'd0);
          chk("leftover_grants", 32'(gq.size()), 32'd0);
          mon_done = 1'b1;
        end
      end
    end
  end

  // Queue the expected words, raise the request and wait (bounded) for the grant.
  task automatic issue(input int id, input logic [AW-1:0] a, input logic [LW-1:0] l,
                       input int budget);
    exp_t e;
    bit   got = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      e.addr = AW'(a + AW'(i));
      e.data = rom_word(e.addr);
      e.last = (i == int'(l));
      if (id == 0) sq0.push_back(e);
      else sq1.push_back(e);
    end
    if (id == 0) begin
      addr0 = a; len0 = l; req0 = 1'b1;
    end else begin
      addr1 = a; len1 = l; req1 = 1'b1;
    end
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if ((id == 0 && gnt0) || (id == 1 && gnt1)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      $display("FAIL grant_timeout: requester %0d got no grant within %0d cycles", id, budget);
      $fatal(1);
    end
    if (id == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  // Wait until every expected word and grant has been consumed.
  task automatic drain(input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (sq0.size() == 0 && sq1.size() == 0 && gq.size() == 0 && !rvalid0 && !rvalid1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      $display("FAIL drain_timeout: words left %0d/%0d grants left %0d",
               sq0.size(), sq1.size(), gq.size());
      $fatal(1);
    end
    @(negedge clk);
  endtask

  initial begin
    int base;
    #2 rst_n = 1'b0;
    #31 rst_n = 1'b1;

    // Round-robin from reset: both held, grants 0,1,0,1.
    gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
    fork
      begin issue(0, 14'd300, 8'd1, 50); issue(0, 14'd310, 8'd1, 50); end
      begin issue(1, 14'd400, 8'd1, 50); issue(1, 14'd410, 8'd1, 50); end
    join
    drain(50);

    // Single word.
    gq.push_back(0);
    issue(0, 14'd5, 8'd0, 20);
    drain(20);

    // Four-word burst on requester 1.
    gq.push_back(1);
    issue(1, 14'd100, 8'd3, 20);
    drain(20);

    // Address wrap: 16382, 16383, 0, 1.
    gq.push_back(0);
    issue(0, 14'd16382, 8'd3, 20);
    drain(20);

    // Reset mid-burst, then a pending requester 1 wins at the first edge.
    gq.push_back(0);
    issue(0, 14'd200, 8'd7, 20);
    base = vcount0;
    for (int c = 0; c < 20 && vcount0 < base + 3; c++) @(negedge clk);
    if (vcount0 < base + 3) begin
      $display("FAIL midburst_timeout: saw %0d words expected 3", vcount0 - base);
      $fatal(1);
    end
    #2 rst_n = 1'b0;
    addr1 = 14'd50; len1 = 8'd0; req1 = 1'b1;
    #10 rst_n = 1'b1;
    gq.push_back(1);
    issue(1, 14'd50, 8'd0, 1);
    drain(20);

    // Maximum length burst.
    gq.push_back(0);
    issue(0, 14'd1000, 8'd255, 20);
    drain(400);

    end_req = 1'b1;
    for (int c = 0; c < 10 && !mon_done; c++) @(negedge clk);
    if (!mon_done) begin
      $display("FAIL monitor_timeout: monitor did not finish");
      $fatal(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
